conv_row_loader: RTL and testbench

Upstream feeder for the convolution FSM: fetches one image row at a time from the on-chip image RAM and streams it into the RAM shift register. It then raises `row_shift_in_rdy` to tell the convolution FSM that a fresh row is staged. On each `shift_row_up` from the FSM it fetches the next row, until all image rows have been delivered.

---
 rtl/conv_row_loader.sv | 151 +++++++++++++++
 tb/tb_conv_row_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/conv_row_loader.sv
// Row fetcher for the convolution datapath: reads one image row per request from
// the image RAM and streams it, in ascending address order, into the RAM shift register.
module conv_row_loader #(
    parameter int DATA_WIDTH   = 8,
    parameter int RAM_SR_DEPTH = 4,
    parameter int NUM_ROWS     = 8,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] row_data,
    output logic                  row_data_valid,
    output logic                  row_shift_in_rdy,
    input  logic                  shift_row_up,
    output logic                  load_done,
    output logic                  busy
);

    localparam int CW = (RAM_SR_DEPTH > 1) ? $clog2(RAM_SR_DEPTH) : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [CW-1:0]         LAST_WORD = CW'(RAM_SR_DEPTH - 1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(NUM_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(RAM_SR_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_READY,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [RW-1:0]         row_idx_q, row_idx_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  valid_q, valid_d;
    logic                  rdy_q, rdy_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_idx_d  = row_idx_q;
        base_d     = base_q;
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        rdy_d      = 1'b0;
        done_d     = 1'b0;
        // RAM returns data one cycle after the strobe, so valid is the strobe delayed.
        valid_d    = rd_en_q;

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d    = S_READ;
                    word_cnt_d = '0;
                    row_idx_d  = '0;
                    base_d     = '0;
                    addr_d     = '0;
                    rd_en_d    = 1'b1;
                end
            end
            S_READ: begin
                if (word_cnt_q == LAST_WORD) begin
                    state_d = S_DRAIN;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    addr_d     = addr_q + 1'b1;
                    rd_en_d    = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_READY;
                rdy_d   = 1'b1;
            end
            S_READY: begin
                if (shift_row_up) begin
                    if (row_idx_q == LAST_ROW) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Running base replaces row_idx*RAM_SR_DEPTH.
                        state_d    = S_READ;
                        row_idx_d  = row_idx_q + 1'b1;
                        base_d     = base_q + ROW_STEP;
                        addr_d     = base_q + ROW_STEP;
                        word_cnt_d = '0;
                        rd_en_d    = 1'b1;
                    end
                end else begin
                    rdy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            row_idx_q  <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_idx_q  <= row_idx_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            valid_q    <= valid_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign ram_rd_en        = rd_en_q;
    assign ram_addr         = addr_q;
    assign row_data         = ram_rd_data;
    assign row_data_valid   = valid_q;
    assign row_shift_in_rdy = rdy_q;
    assign load_done        = done_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_conv_row_loader.sv
// Directed bench for conv_row_loader: R=4, three rows, RAM model data = address + 8'h10.
module tb_conv_row_loader;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int NR = 3;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          shift_row_up = 1'b0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rd_data = 8'hEE;
    logic [DW-1:0] row_data;
    logic          row_data_valid, row_shift_in_rdy, load_done, busy;

    int checks = 0;
    int errors = 0;

    conv_row_loader #(
        .DATA_WIDTH(DW), .RAM_SR_DEPTH(R), .NUM_ROWS(NR), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .row_data(row_data), .row_data_valid(row_data_valid),
        .row_shift_in_rdy(row_shift_in_rdy), .shift_row_up(shift_row_up),
        .load_done(load_done), .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM; junk when not strobed.
    always @(posedge clock)
        ram_rd_data <= ram_rd_en ? (DW'(ram_addr) + 8'h10) : 8'hEE;

    typedef struct {
        logic          start;
        logic          shift;
        logic          en;
        logic [AW-1:0] addr;
        logic          valid;
        logic [DW-1:0] data;
        logic          rdy;
        logic          done;
        logic          busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic st, input logic sh, input logic en, input int addr,
                        input logic vl, input int data, input logic rdy, input logic dn,
                        input logic bz);
        vec_t v;
        v.start = st; v.shift = sh; v.en = en; v.addr = AW'(addr);
        v.valid = vl; v.data = DW'(data); v.rdy = rdy; v.done = dn; v.busy = bz;
        vecs.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".en"},    32'(ram_rd_en), 0);
        chk({tag, ".addr"},  32'(ram_addr), 0);
        chk({tag, ".valid"}, 32'(row_data_valid), 0);
        chk({tag, ".rdy"},   32'(row_shift_in_rdy), 0);
        chk({tag, ".done"},  32'(load_done), 0);
        chk({tag, ".busy"},  32'(busy), 0);
    endtask

    initial begin
        // Frame A: pulsed shift_row_up, start while busy ignored.
        //   st sh en addr vl data  rdy dn bz
        push(1, 0, 1, 0,  0, 0,    0, 0, 1);
        push(0, 0, 1, 1,  1, 'h10, 0, 0, 1);
        push(0, 0, 1, 2,  1, 'h11, 0, 0, 1);
        push(0, 0, 1, 3,  1, 'h12, 0, 0, 1);
        push(0, 0, 0, 0,  1, 'h13, 0, 0, 1);
        push(0, 0, 0, 0,  0, 0,    1, 0, 1);
        push(1, 0, 0, 0,  0, 0,    1, 0, 1);
        push(0, 1, 1, 4,  0, 0,    0, 0, 1);
        push(1, 0, 1, 5,  1, 'h14, 0, 0, 1);
        push(0, 0, 1, 6,  1, 'h15, 0, 0, 1);
        push(0, 0, 1, 7,  1, 'h16, 0, 0, 1);
        push(0, 0, 0, 0,  1, 'h17, 0, 0, 1);
        push(0, 0, 0, 0,  0, 0,    1, 0, 1);
        push(0, 1, 1, 8,  0, 0,    0, 0, 1);
        push(0, 0, 1, 9,  1, 'h18, 0, 0, 1);
        push(0, 0, 1, 10, 1, 'h19, 0, 0, 1);
        push(0, 0, 1, 11, 1, 'h1a, 0, 0, 1);
        push(0, 0, 0, 0,  1, 'h1b, 0, 0, 1);
        push(0, 0, 0, 0,  0, 0,    1, 0, 1);
        push(0, 1, 0, 0,  0, 0,    0, 1, 1);
        push(0, 0, 0, 0,  0, 0,    0, 0, 0);
        push(0, 1, 0, 0,  0, 0,    0, 0, 0);
        // Frame B: start+shift in IDLE (start wins), shift held 3 cycles during row 1 READ.
        push(1, 1, 1, 0,  0, 0,    0, 0, 1);
        push(0, 0, 1, 1,  1, 'h10, 0, 0, 1);
        push(0, 0, 1, 2,  1, 'h11, 0, 0, 1);
        push(0, 0, 1, 3,  1, 'h12, 0, 0, 1);
        push(0, 0, 0, 0,  1, 'h13, 0, 0, 1);
        push(0, 0, 0, 0,  0, 0,    1, 0, 1);
        push(0, 1, 1, 4,  0, 0,    0, 0, 1);
        push(0, 1, 1, 5,  1, 'h14, 0, 0, 1);
        push(0, 1, 1, 6,  1, 'h15, 0, 0, 1);
        push(0, 1, 1, 7,  1, 'h16, 0, 0, 1);
        push(0, 0, 0, 0,  1, 'h17, 0, 0, 1);
        push(0, 0, 0, 0,  0, 0,    1, 0, 1);
        push(0, 0, 0, 0,  0, 0,    1, 0, 1);
        push(0, 1, 1, 8,  0, 0,    0, 0, 1);
        push(0, 0, 1, 9,  1, 'h18, 0, 0, 1);
        push(0, 0, 1, 10, 1, 'h19, 0, 0, 1);
        push(0, 0, 1, 11, 1, 'h1a, 0, 0, 1);
        push(0, 0, 0, 0,  1, 'h1b, 0, 0, 1);
        push(0, 0, 0, 0,  0, 0,    1, 0, 1);
        push(0, 1, 0, 0,  0, 0,    0, 1, 1);
        push(0, 0, 0, 0,  0, 0,    0, 0, 0);

        #12;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("v%0d", i);
            @(negedge clock);
            start        = vecs[i].start;
            shift_row_up = vecs[i].shift;
            @(posedge clock);
            #1;
            chk({t, ".en"},    32'(ram_rd_en), 32'(vecs[i].en));
            chk({t, ".valid"}, 32'(row_data_valid), 32'(vecs[i].valid));
            chk({t, ".rdy"},   32'(row_shift_in_rdy), 32'(vecs[i].rdy));
            chk({t, ".done"},  32'(load_done), 32'(vecs[i].done));
            chk({t, ".busy"},  32'(busy), 32'(vecs[i].busy));
            if (vecs[i].en || !vecs[i].busy)
                chk({t, ".addr"}, 32'(ram_addr), 32'(vecs[i].addr));
            if (vecs[i].valid)
                chk({t, ".data"}, 32'(row_data), 32'(vecs[i].data));
        end
        @(negedge clock);
        start = 1'b0;
        shift_row_up = 1'b0;

        // Async reset during READ of row 1, at address 5.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("ar.rdy", 32'(row_shift_in_rdy), 1);
        shift_row_up = 1'b1;
        @(negedge clock);
        shift_row_up = 1'b0;
        @(posedge clock);
        #1;
        chk("ar.addr5", 32'(ram_addr), 5);
        chk("ar.en5", 32'(ram_rd_en), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("ar.async");
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        chk("rs.en0", 32'(ram_rd_en), 1);
        chk("rs.addr0", 32'(ram_addr), 0);
        chk("rs.busy", 32'(busy), 1);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("rs.addr1", 32'(ram_addr), 1);
        chk("rs.valid", 32'(row_data_valid), 1);
        chk("rs.data", 32'(row_data), 'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
